face_overlay: RTL and testbench

//  Back end of the face-detect core path: reads one core tile of raw pixels plus the per-pixel face mask
//  (1 = rectangle border) written by a detection core, and emits the composited tile in raster order.

---
 rtl/face_pkg.sv | 23 ++
 rtl/face_overlay_fifo.sv | 43 ++++
 rtl/face_overlay.sv | 153 +++++++++++++++
 tb/tb_face_overlay.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/face_pkg.sv
// Shared definitions for the face overlay path: default marker value, FSM encoding, tile size helper.
package face_pkg;

    localparam int WHITE_PIX_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // unit = size/8 (truncating), side = 3*unit, total = side*side, all in 32 bits
    function automatic logic [31:0] tile_total(input logic [31:0] size);
        logic [31:0] unit;
        logic [31:0] side;
        unit = size >> 3;
        side = unit * 32'd3;
        return side * side;
    endfunction

endpackage

// File: rtl/face_overlay_fifo.sv
// Synchronous output FIFO carrying {last, pixel}; head is shown combinationally, count reports occupancy.
module overlay_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/face_overlay.sv
// Composites the detection mask onto one core tile of raw pixels, streaming the result in raster order.
// Define OVERLAY_STATS_EN to add the mark_count port (pixels replaced in the current/last tile).
//
//  state    | meaning
//  IDLE     | waiting for start
//  CHECK    | size latched, tile total computed; zero total ends with error
//  RUN      | accepting pixels until idx reaches total
//  DRAIN    | all pixels accepted, emptying s0 and FIFO
//  DONE     | one-cycle done (and error) pulse
module face_overlay
    import face_pkg::*;
#(
    parameter int PIX_W     = 32,
    parameter int ADDR_W    = 17,
    parameter int WHITE_PIX = WHITE_PIX_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         size,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic                pix_valid,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                pix_ready,
    output logic                mask_rd_en,
    output logic [ADDR_W-1:0]   mask_addr,
    input  logic                mask_rdata,
    output logic                out_valid,
    output logic [PIX_W-1:0]    out_data,
    output logic                out_last,
    input  logic                out_ready
`ifdef OVERLAY_STATS_EN
    ,
    output logic [ADDR_W:0]     mark_count
`endif
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [PIX_W-1:0] WHITE_V  = PIX_W'(WHITE_PIX);
    localparam logic [CW:0]      DEPTH_L  = (CW+1)'(OUT_DEPTH);
    localparam logic [ADDR_W:0]  ONE      = 1;

    state_t            state, state_nxt;
    logic [31:0]       size_q;
    logic [ADDR_W:0]   total_q;
    logic [ADDR_W:0]   total_calc;
    logic [ADDR_W:0]   idx;
    logic              s0_valid;
    logic [PIX_W-1:0]  s0_data;
    logic              s0_last;
    logic              last_popped;
    logic              accept;
    logic              push;
    logic              pop;
    logic [PIX_W:0]    push_data;
    logic [PIX_W:0]    fifo_head;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic              head_last;
    logic              drain_done;

    assign total_calc = (ADDR_W+1)'(tile_total(size_q));
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, s0_valid};
    assign accept     = pix_valid && pix_ready;
    assign push       = s0_valid;
    assign push_data  = {s0_last, (mask_rdata ? WHITE_V : s0_data)};
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign head_last  = fifo_head[PIX_W];
    assign out_data   = out_valid ? fifo_head[PIX_W-1:0] : '0;
    assign out_last   = out_valid && head_last;
    assign mask_rd_en = accept;
    assign mask_addr  = idx[ADDR_W-1:0];

    // The final pixel may be leaving the FIFO this very cycle; finish without an extra idle cycle.
    assign drain_done = !s0_valid &&
                        ((fifo_count == '0 && last_popped) ||
                         (pop && head_last && fifo_count == CW'(1)));

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (total_calc == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (idx == total_q) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_CHECK) || (state == ST_RUN) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        error     = (state == ST_DONE) && (total_q == '0);
        pix_ready = (state == ST_RUN) && (idx < total_q) && (occupancy < DEPTH_L);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            size_q      <= '0;
            total_q     <= '0;
            idx         <= '0;
            s0_valid    <= 1'b0;
            s0_data     <= '0;
            s0_last     <= 1'b0;
            last_popped <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                size_q      <= size;
                idx         <= '0;
                last_popped <= 1'b0;
            end
            if (state == ST_CHECK) total_q <= total_calc;
            s0_valid <= accept;
            if (accept) begin
                s0_data <= pix_data;
                s0_last <= (idx + ONE == total_q);
                idx     <= idx + ONE;
            end
            if (pop && head_last) last_popped <= 1'b1;
        end
    end

    overlay_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (PIX_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

`ifdef OVERLAY_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)                       mark_count <= '0;
        else if (state == ST_IDLE && start) mark_count <= '0;
        else if (push && mask_rdata)      mark_count <= mark_count + ONE;
    end
`endif

endmodule

// File: tb/tb_face_overlay.sv
// Directed bench for face_overlay: ramp tiles with blank/border masks, backpressure, zero-size error, mid-tile reset.
module tb_face_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] size;
    logic        busy, done, error;
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        pix_ready;
    logic        mask_rd_en;
    logic [16:0] mask_addr;
    logic        mask_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
`ifdef OVERLAY_STATS_EN
    logic [17:0] mark_count;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic mask_mem [0:255];
    int   acc_cyc  [0:255];

    always #5 clk = ~clk;

    face_overlay dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size       (size),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .mask_rd_en (mask_rd_en),
        .mask_addr  (mask_addr),
        .mask_rdata (mask_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
`ifdef OVERLAY_STATS_EN
        ,
        .mark_count (mark_count)
`endif
    );

    // mask store: one-cycle registered read
    always @(posedge clk) begin
        if (mask_rd_en) mask_rdata <= mask_mem[mask_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_mask(input bit border);
        for (int i = 0; i < 256; i++)
            mask_mem[i] = border && ((i < 9) || (i % 9 == 0));
    endtask

    task automatic do_start(input logic [31:0] sz);
        @(negedge clk);
        size  = sz;
        start = 1'b1;
    endtask

    // mode 0: out_ready held 1; mode 1: out_ready 1 of 3 cycles. abort_at>0 stops after that many accepts.
    task automatic run_tile(input int mode, input int abort_at, input int exp_whites);
        int  in_idx, out_idx, whites, last_pop;
        bit  saw_bp, finished;
        logic exp_rdy;
        logic [31:0] exp_pix;
        in_idx = 0; out_idx = 0; whites = 0; last_pop = -10;
        saw_bp = 0; finished = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            start     = (mode == 0 && cyc == 10);
            if (cyc == 0) size = 32'd0;
            pix_valid = (in_idx < 81);
            pix_data  = in_idx;
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (cyc == 0) check("check_busy", busy, 1'b1);
            exp_rdy = (cyc >= 1) && (in_idx < 81) && ((in_idx - out_idx) < 4);
            check("pix_ready", pix_ready, exp_rdy);
            if (cyc >= 1 && in_idx < 81 && !pix_ready) saw_bp = 1;
            if (done) begin
                check("done_after_last", cyc, last_pop + 1);
                check("out_count", out_idx, 81);
                check("error_clear", error, 1'b0);
                check("whites", whites, exp_whites);
`ifdef OVERLAY_STATS_EN
                check("mark_count", mark_count, exp_whites);
`endif
                finished = 1;
                break;
            end
            if (pix_valid && pix_ready) begin
                check("mask_addr", mask_addr, in_idx);
                check("mask_rd_en", mask_rd_en, 1'b1);
                acc_cyc[in_idx] = cyc;
                if (mode == 0) check("throughput", cyc, in_idx + 1);
                in_idx++;
            end
            if (out_valid && out_ready) begin
                exp_pix = mask_mem[out_idx] ? 32'd255 : out_idx;
                check("out_data", out_data, exp_pix);
                check("out_last", out_last, out_idx == 80);
                if (mode == 0) check("latency", cyc - acc_cyc[out_idx], 2);
                if (out_data == 32'd255) whites++;
                last_pop = cyc;
                out_idx++;
            end
            if (abort_at > 0 && in_idx == abort_at) begin
                finished = 1;
                break;
            end
        end
        if (!finished) check("timeout", 0, 1);
        if (mode == 1) check("backpressure_seen", saw_bp, 1'b1);
        if (abort_at == 0) begin
            @(negedge clk);
            start = 1'b0; pix_valid = 1'b0;
            #1;
            check("done_pulse_1cyc", done, 1'b0);
            check("busy_after_done", busy, 1'b0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_pix_ready"}, pix_ready, 1'b0);
        check({tag, "_mask_rd_en"}, mask_rd_en, 1'b0);
        check({tag, "_mask_addr"}, mask_addr, 17'd0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; size = 32'd0;
        pix_valid = 1'b0; pix_data = 32'd0; out_ready = 1'b0;
        mask_rdata = 1'b0;
        set_mask(0);
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef OVERLAY_STATS_EN
        check("reset_mark_count", mark_count, 18'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // plain ramp, mask clear
        do_start(32'd24);
        @(negedge clk);
        run_tile(0, 0, 0);

        // border mask on row 0 and column 0
        set_mask(1);
        do_start(32'd24);
        @(negedge clk);
        run_tile(0, 0, 17);

        // backpressure; mark count cleared by this start
        do_start(32'd24);
        @(negedge clk);
`ifdef OVERLAY_STATS_EN
        #1;
        check("mark_count_cleared", mark_count, 18'd0);
`endif
        run_tile(1, 0, 17);

        // size 7 -> unit 0 -> error
        do_start(32'd7);
        begin
            bit seen;
            seen = 0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                pix_valid = 1'b1;
                out_ready = 1'b1;
                #1;
                check("err_pix_ready", pix_ready, 1'b0);
                check("err_out_valid", out_valid, 1'b0);
                check("err_done", done, cyc == 1);
                check("err_error", error, cyc == 1);
                if (done) seen = 1;
            end
            check("err_done_seen", seen, 1'b1);
            pix_valid = 1'b0;
        end

        // mid-tile reset after 40 accepts, then a clean tile
        set_mask(0);
        do_start(32'd24);
        @(negedge clk);
        run_tile(0, 40, 0);
        @(negedge clk);
        reset = 1'b0;
        pix_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        do_start(32'd24);
        @(negedge clk);
        run_tile(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
